// File: rtl/prio_enc_disp.sv
// Debounced priority encoder: commits the highest set bit of x after STABLE_CYC stable cycles, shows it on two hex digits.
// Latency: x first sampled at edge E and held -> idx/valid/changed update at edge E+STABLE_CYC+1; display follows idx combinationally.
// Backpressure: none; free-running sampler, any input change before commit restarts the debounce and holds the old result.
module prio_enc_disp #(
    parameter  int WIDTH      = 16,
    parameter  int STABLE_CYC = 4,
    localparam int IDX_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] x,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             changed,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1
);

    // Counter only has to reach STABLE_CYC, where it saturates.
    localparam int              CNT_W   = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

    // Glyphs, active-low {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic [WIDTH-1:0] x_q,       x_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             en_r_q,    en_r_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             valid_q,   valid_d;
    logic             changed_q, changed_d;

    logic [IDX_W-1:0] enc;
    logic [7:0]       idx_ext;

    // Hex glyph for one nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Priority encode the registered vector; later (higher) bits overwrite lower ones, 0 when empty.
    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x_q[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

    // Debounce counter, commit and change-detect; disable clears everything but keeps x_q tracking.
    always_comb begin
        x_d       = x;
        en_r_d    = enable;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (enable) begin
            if (x != x_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Commit uses x_q, which has been stable for STABLE_CYC edges when cnt_q saturates.
            if (cnt_q == CNT_MAX) begin
                idx_d     = enc;
                valid_d   = |x_q;
                changed_d = ({valid_d, idx_d} != {valid_q, idx_q});
            end
        end else begin
            cnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            cnt_q     <= '0;
            en_r_q    <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            en_r_q    <= en_r_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    // Display decode: blank when disabled, dash when nothing committed, else hex digits of idx.
    always_comb begin
        idx_ext              = '0;
        idx_ext[IDX_W-1:0]   = idx_q;
        hex0                 = SEG_BLANK;
        hex1                 = SEG_BLANK;
        if (en_r_q) begin
            if (!valid_q) begin
                hex0 = SEG_DASH;
                hex1 = SEG_DASH;
            end else begin
                hex0 = seg7(idx_ext[3:0]);
                hex1 = seg7(idx_ext[7:4]);
            end
        end
    end

    assign idx     = idx_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule
